// File: rtl/md_ctrl_pkg.sv
// Shared multiply/divide op-code definitions for the decoder, stall unit and md_ctrl.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
package md_ctrl_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MFHI  = 4'd7,
        MD_MFLO  = 4'd8
    } md_op_e;

    // True for the ops that occupy the unit for several cycles.
    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_ctrl_if.sv
// Bundle between the E-stage (master) and the multiply/divide unit (slave).
// Latency: n/a (wires only).
// Backpressure: md_stall/md_busy flow back to the master; the master must hold off while stalled.
interface md_ctrl_if;

    logic        md_start;
    logic [3:0]  md_op;
    logic [31:0] md_a;
    logic [31:0] md_b;
    logic        md_busy;
    logic        md_stall;
    logic [31:0] md_rdata;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output md_start, md_op, md_a, md_b,
        input  md_busy, md_stall, md_rdata, hi, lo
    );

    modport slave (
        input  md_start, md_op, md_a, md_b,
        output md_busy, md_stall, md_rdata, hi, lo
    );

endinterface

// File: rtl/md_ctrl.sv
// Multi-cycle HI/LO multiply/divide unit with MTHI/MTLO/MFHI/MFLO access.
// Latency: mult/div results land in HI/LO N cycles after the start edge; MTHI/MTLO take effect at the start edge.
// Backpressure: md_stall is raised combinationally on a mult/div start and held while busy; starts while busy are dropped.
module md_ctrl
    import md_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic     clk,
    input  logic     reset,
    md_ctrl_if.slave md
);

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      pend_hi_q, pend_hi_d;
    logic [31:0]      pend_lo_q, pend_lo_d;

    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic signed [31:0] quot_s, rem_s;
    logic [31:0]        quot_u, rem_u;
    logic               b_zero;
    logic               busy;

    // Arithmetic datapath; the divider inputs are masked on a zero divisor.
    always_comb begin
        prod_s = $signed({{32{md.md_a[31]}}, md.md_a}) * $signed({{32{md.md_b[31]}}, md.md_b});
        prod_u = {32'd0, md.md_a} * {32'd0, md.md_b};
        b_zero = (md.md_b == 32'd0);
        quot_s = b_zero ? 32'sd0 : $signed(md.md_a) / $signed(md.md_b);
        rem_s  = b_zero ? 32'sd0 : $signed(md.md_a) % $signed(md.md_b);
        quot_u = b_zero ? 32'd0  : md.md_a / md.md_b;
        rem_u  = b_zero ? 32'd0  : md.md_a % md.md_b;
    end

    // State register: synchronous reset clears everything, aborting any operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
        end
    end

    // Next state: count down while busy and commit on the last count; accept new ops only when idle.
    always_comb begin
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                hi_d = pend_hi_q;
                lo_d = pend_lo_q;
            end
        end else if (md.md_start) begin
            case (md.md_op)
                MD_MULT: begin
                    cnt_d     = CNT_W'(MULT_CYCLES);
                    pend_hi_d = prod_s[63:32];
                    pend_lo_d = prod_s[31:0];
                end
                MD_MULTU: begin
                    cnt_d     = CNT_W'(MULT_CYCLES);
                    pend_hi_d = prod_u[63:32];
                    pend_lo_d = prod_u[31:0];
                end
                MD_DIV, MD_DIVU: begin
                    cnt_d = CNT_W'(DIV_CYCLES);
                    // A zero divisor re-commits the current HI/LO, so they appear unchanged.
                    // HI/LO cannot move while busy because every start is dropped then.
                    if (b_zero) begin
                        pend_hi_d = hi_q;
                        pend_lo_d = lo_q;
                    end else if (md.md_op == MD_DIV) begin
                        pend_hi_d = rem_s;
                        pend_lo_d = quot_s;
                    end else begin
                        pend_hi_d = rem_u;
                        pend_lo_d = quot_u;
                    end
                end
                MD_MTHI: hi_d = md.md_a;
                MD_MTLO: lo_d = md.md_a;
                default: ;
            endcase
        end
    end

    // Outputs: stall covers the start cycle so the next md instruction waits without a gap.
    always_comb begin
        busy        = (cnt_q != '0);
        md.md_busy  = busy;
        md.md_stall = (md.md_start && is_muldiv(md.md_op)) || busy;
        md.hi       = hi_q;
        md.lo       = lo_q;
        case (md.md_op)
            MD_MFHI: md.md_rdata = hi_q;
            MD_MFLO: md.md_rdata = lo_q;
            default: md.md_rdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_md_ctrl.sv
// Directed bench for md_ctrl: per-cycle expected observations queued by the stimulus, checked by a monitor.
// Latency: one expectation per clock, consumed on the falling edge of the same cycle.
// Backpressure: stimulus honours md_stall by issuing only the starts it expects to be dropped.
module tb_md_ctrl;
    import md_ctrl_pkg::*;

    typedef struct {
        string       nm;
        logic        busy;
        logic        stall;
        logic [31:0] rdata;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic clk;
    logic reset;
    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    md_ctrl_if mif();

    md_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (mif.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of inputs without queuing an expectation.
    task automatic drive(input logic rst, input logic st, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1;
        reset        = rst;
        mif.md_start = st;
        mif.md_op    = op;
        mif.md_a     = a;
        mif.md_b     = b;
    endtask

    // Drive one cycle and queue what the DUT must show during that cycle.
    task automatic cyc(input logic rst, input logic st, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b, input string nm,
                       input logic busy, input logic stall, input logic [31:0] rd,
                       input logic [31:0] h, input logic [31:0] l);
        exp_t e;
        drive(rst, st, op, a, b);
        e.nm = nm; e.busy = busy; e.stall = stall; e.rdata = rd; e.hi = h; e.lo = l;
        exp_q.push_back(e);
    endtask

    // Monitor: pop and compare away from the active edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_vec++;
            if (mif.md_busy !== e.busy || mif.md_stall !== e.stall || mif.md_rdata !== e.rdata ||
                mif.hi !== e.hi || mif.lo !== e.lo) begin
                n_miss++;
                $display("FAIL %s: got busy=%b stall=%b rdata=%h hi=%h lo=%h, want busy=%b stall=%b rdata=%h hi=%h lo=%h",
                         e.nm, mif.md_busy, mif.md_stall, mif.md_rdata, mif.hi, mif.lo,
                         e.busy, e.stall, e.rdata, e.hi, e.lo);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        mif.md_start = 1'b0;
        mif.md_op    = MD_NONE;
        mif.md_a     = 32'd0;
        mif.md_b     = 32'd0;
        drive(1'b1, 1'b0, MD_NONE, 32'd0, 32'd0);
        drive(1'b1, 1'b0, MD_NONE, 32'd0, 32'd0);
        cyc(0, 0, MD_NONE, 0, 0, "rst_state", 0, 0, 0, 0, 0);

        // MULT -1 * 2
        cyc(0, 1, MD_MULT, 32'hFFFFFFFF, 32'd2, "mult_start", 0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++)
            cyc(0, 0, MD_NONE, 0, 0, "mult_busy", 1, 1, 0, 0, 0);
        cyc(0, 1, MD_MFHI, 0, 0, "mult_mfhi", 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
        cyc(0, 1, MD_MFLO, 0, 0, "mult_mflo", 0, 0, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFE);

        // MULTU 0xFFFFFFFF * 2; MFHI while busy must show the old HI
        cyc(0, 1, MD_MULTU, 32'hFFFFFFFF, 32'd2, "multu_start", 0, 1, 0, 32'hFFFFFFFF, 32'hFFFFFFFE);
        for (int i = 0; i < 5; i++)
            cyc(0, 0, MD_MFHI, 0, 0, "multu_busy", 1, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
        cyc(0, 0, MD_NONE, 0, 0, "multu_done", 0, 0, 0, 32'h00000001, 32'hFFFFFFFE);

        // DIV -7 / 2 -> q=-3, r=-1
        cyc(0, 1, MD_DIV, 32'hFFFFFFF9, 32'd2, "div_start", 0, 1, 0, 32'h00000001, 32'hFFFFFFFE);
        for (int i = 0; i < 10; i++)
            cyc(0, 0, MD_NONE, 0, 0, "div_busy", 1, 1, 0, 32'h00000001, 32'hFFFFFFFE);
        cyc(0, 0, MD_NONE, 0, 0, "div_done", 0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFD);

        // DIVU 0xFFFFFFF9 / 2 -> q=0x7FFFFFFC, r=1
        cyc(0, 1, MD_DIVU, 32'hFFFFFFF9, 32'd2, "divu_start", 0, 1, 0, 32'hFFFFFFFF, 32'hFFFFFFFD);
        for (int i = 0; i < 10; i++)
            cyc(0, 0, MD_NONE, 0, 0, "divu_busy", 1, 1, 0, 32'hFFFFFFFF, 32'hFFFFFFFD);
        cyc(0, 0, MD_NONE, 0, 0, "divu_done", 0, 0, 0, 32'h00000001, 32'h7FFFFFFC);

        // DIVU 7 / 0: full duration, HI/LO unchanged
        cyc(0, 1, MD_DIVU, 32'd7, 32'd0, "div0_start", 0, 1, 0, 32'h00000001, 32'h7FFFFFFC);
        for (int i = 0; i < 10; i++)
            cyc(0, 0, MD_NONE, 0, 0, "div0_busy", 1, 1, 0, 32'h00000001, 32'h7FFFFFFC);
        cyc(0, 0, MD_NONE, 0, 0, "div0_done", 0, 0, 0, 32'h00000001, 32'h7FFFFFFC);

        // MTHI/MTLO and readback, never busy
        cyc(0, 1, MD_MTHI, 32'h12345678, 0, "mthi", 0, 0, 0, 32'h00000001, 32'h7FFFFFFC);
        cyc(0, 1, MD_MFHI, 0, 0, "mfhi", 0, 0, 32'h12345678, 32'h12345678, 32'h7FFFFFFC);
        cyc(0, 1, MD_MTLO, 32'hCAFEF00D, 0, "mtlo", 0, 0, 0, 32'h12345678, 32'h7FFFFFFC);
        cyc(0, 1, MD_MFLO, 0, 0, "mflo", 0, 0, 32'hCAFEF00D, 32'h12345678, 32'hCAFEF00D);

        // Unused op codes behave as NONE
        cyc(0, 1, 4'hF, 32'hAAAA, 32'hBBBB, "op15", 0, 0, 0, 32'h12345678, 32'hCAFEF00D);
        cyc(0, 1, 4'h9, 32'hAAAA, 32'hBBBB, "op9", 0, 0, 0, 32'h12345678, 32'hCAFEF00D);

        // MULT 3 * -4 with an MTLO in busy cycle 2 that must be dropped
        cyc(0, 1, MD_MULT, 32'd3, 32'hFFFFFFFC, "mult2_start", 0, 1, 0, 32'h12345678, 32'hCAFEF00D);
        cyc(0, 0, MD_NONE, 0, 0, "mult2_b1", 1, 1, 0, 32'h12345678, 32'hCAFEF00D);
        cyc(0, 1, MD_MTLO, 32'hDEADBEEF, 0, "mult2_mtlo", 1, 1, 0, 32'h12345678, 32'hCAFEF00D);
        for (int i = 0; i < 3; i++)
            cyc(0, 0, MD_NONE, 0, 0, "mult2_busy", 1, 1, 0, 32'h12345678, 32'hCAFEF00D);
        cyc(0, 0, MD_NONE, 0, 0, "mult2_done", 0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFF4);

        // DIV 100 / 7 aborted by reset in busy cycle 4; reset also beats an MTHI start
        cyc(0, 1, MD_DIV, 32'd100, 32'd7, "div2_start", 0, 1, 0, 32'hFFFFFFFF, 32'hFFFFFFF4);
        for (int i = 0; i < 3; i++)
            cyc(0, 0, MD_NONE, 0, 0, "div2_busy", 1, 1, 0, 32'hFFFFFFFF, 32'hFFFFFFF4);
        cyc(1, 0, MD_NONE, 0, 0, "div2_rst_cycle", 1, 1, 0, 32'hFFFFFFFF, 32'hFFFFFFF4);
        cyc(1, 1, MD_MTHI, 32'h55555555, 0, "rst_prio", 0, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++)
            cyc(0, 0, MD_NONE, 0, 0, "post_rst", 0, 0, 0, 0, 0);

        @(posedge clk);
        @(negedge clk);
        #1;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/md_ctrl.md
MD_CTRL -- requirements
Module: md_ctrl

Interface
REQ-001 Parameter MULT_CYCLES, default 5, busy duration in cycles for mult/multu.
REQ-002 Parameter DIV_CYCLES, default 10, busy duration in cycles for div/divu.
REQ-003 clk  input  1  the single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 md_start  input  1  E-stage instruction carries a valid md_op this cycle.
REQ-006 md_op  input  4  operation code from the shared package.
REQ-007 md_a  input  32  forwarded rs value.
REQ-008 md_b  input  32  forwarded rt value.
REQ-009 md_busy  output  1  high while an operation is in progress.
REQ-010 md_stall  output  1  combinational md_start-with-mult/div-op OR md_busy; drives the stall unit's MD-stall input.
REQ-011 md_rdata  output  32  HI for MFHI, LO for MFLO, else 0; combinational.
REQ-012 hi, lo  output  32 each  architectural HI/LO registers, for debug.

Function
REQ-013 Op codes: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MFHI=7, MFLO=8; codes 9-15 behave as NONE.
REQ-014 States: IDLE (cnt==0) and BUSY (cnt!=0); md_busy = (cnt!=0).
REQ-015 In IDLE, md_start with MULT/MULTU loads cnt=MULT_CYCLES; with DIV/DIVU loads cnt=DIV_CYCLES; result latched into pending_hi/pending_lo at the same edge.
REQ-016 MULT: signed 32x32->64, pending_hi=upper 32, pending_lo=lower 32; MULTU identical but unsigned.
REQ-017 DIV: signed, pending_lo=quotient truncated toward zero, pending_hi=remainder with dividend's sign; DIVU unsigned.
REQ-018 Divide by zero: operation still occupies DIV_CYCLES, HI/LO retain prior values at completion.
REQ-019 In BUSY, cnt decrements by 1 per cycle; on the edge where cnt==1, hi/lo <= pending values and cnt becomes 0.
REQ-020 Latency: start at edge T -> md_busy high for cycles T+1..T+N exactly, new HI/LO visible from cycle T+N+1 (N = MULT_CYCLES or DIV_CYCLES).
REQ-021 MTHI/MTLO with md_start in IDLE write md_a into hi/lo at that edge, no busy cycles.
REQ-022 MFHI/MFLO read current hi/lo; md_rdata never exposes pending values.
REQ-023 md_start while md_busy is ignored (no state change, cnt unaffected); md_stall guarantees upstream never relies on it.
REQ-024 md_stall is high in the start cycle of a mult/div so the following D-stage md instruction stalls without a bubble gap.
REQ-025 md_start low: no state change except cnt decrement.

Reset
REQ-026 reset high at a rising edge: hi=0, lo=0, pending_hi=0, pending_lo=0, cnt=0; md_busy=0 from the next cycle.
REQ-027 reset mid-operation aborts it; pending result is discarded, never committed.
REQ-028 reset has priority over md_start in the same cycle.

Structure
REQ-029 Op-code constants MD_NONE..MD_MFLO belong in the shared macro package, used also by the control decoder and the stall unit.
REQ-030 cnt width is sized to hold max(MULT_CYCLES, DIV_CYCLES); no other constants are local.
REQ-031 Single module, no sub-modules; arithmetic uses the synthesizer's multiplier/divider operators.

Verification
REQ-032 MULT a=0xFFFFFFFF, b=2 at T -> busy T+1..T+5, T+6 hi=0xFFFFFFFF, lo=0xFFFFFFFE; MULTU same operands -> hi=0x00000001, lo=0xFFFFFFFE.
REQ-033 DIV a=0xFFFFFFF9(-7), b=2 -> busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=7, b=0 -> hi/lo unchanged after 10 busy cycles.
REQ-034 MTHI a=0x12345678 then MFHI next cycle -> md_rdata=0x12345678, md_busy never asserted.
REQ-035 MULT started, MTLO issued at busy cycle 2 -> ignored; lo after completion equals the MULT result.
REQ-036 DIV started, reset at busy cycle 4 -> hi=lo=0, md_busy=0 next cycle, no later commit.
REQ-037 md_start with MULT at T -> md_stall=1 at T (combinational) through T+5, 0 at T+6.
